// File: rtl/gfx_compositor.sv
// Rectangle-object compositor: a raster scan generator feeding a ready/valid pixel
// stream, with double-buffered object registers that swap at the end of each frame.
module gfx_compositor #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int N_OBJ    = 4,
  parameter int COORD_W  = 16,
  parameter int COLOR_W  = 3,
  parameter int ADDR_W   = 19,
  parameter int BG_COLOR = 0,
  localparam int OBJ_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [OBJ_W-1:0]   wr_obj,
  input  logic [1:0]         wr_field,
  input  logic [COORD_W-1:0] wr_data,
  input  logic               pixel_ready,
  output logic               pixel_valid,
  output logic [COLOR_W-1:0] color,
  output logic [ADDR_W-1:0]  pixel_address,
  output logic               frame_start
);

  logic [COORD_W-1:0] r_sh_x [N_OBJ], r_sh_y [N_OBJ], r_ac_x [N_OBJ], r_ac_y [N_OBJ];
  logic [7:0]         r_sh_w [N_OBJ], r_sh_h [N_OBJ], r_ac_w [N_OBJ], r_ac_h [N_OBJ];
  logic [COLOR_W-1:0] r_sh_c [N_OBJ], r_ac_c [N_OBJ];
  logic               r_sh_en [N_OBJ], r_ac_en [N_OBJ];

  logic [COORD_W-1:0] w_nx_x [N_OBJ], w_nx_y [N_OBJ];
  logic [7:0]         w_nx_w [N_OBJ], w_nx_h [N_OBJ];
  logic [COLOR_W-1:0] w_nx_c [N_OBJ];
  logic               w_nx_en [N_OBJ];

  logic [COORD_W-1:0] r_scan_x, r_scan_y;
  logic [ADDR_W-1:0]  r_scan_addr;
  logic               r_valid, r_fs;
  logic [COLOR_W-1:0] r_color;
  logic [ADDR_W-1:0]  r_addr;

  logic               w_load, w_last_x, w_last_y, w_last;
  logic [COORD_W:0]   w_px, w_py;
  logic [N_OBJ-1:0]   w_cov;
  logic [COLOR_W-1:0] w_color;
  logic               w_unused_data;

  assign w_unused_data = &{1'b0, wr_data};

  assign w_load   = !r_valid || pixel_ready;
  assign w_last_x = (r_scan_x == COORD_W'(H_RES - 1));
  assign w_last_y = (r_scan_y == COORD_W'(V_RES - 1));
  assign w_last   = w_last_x && w_last_y;
  assign w_px     = {1'b0, r_scan_x};
  assign w_py     = {1'b0, r_scan_y};

  // Shadow contents after this edge's write; also what the active set loads on a swap,
  // so a write landing on the swap edge reaches both copies.
  always_comb begin
    w_nx_x  = r_sh_x;
    w_nx_y  = r_sh_y;
    w_nx_w  = r_sh_w;
    w_nx_h  = r_sh_h;
    w_nx_c  = r_sh_c;
    w_nx_en = r_sh_en;
    if (wr_en) begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        if (wr_obj == OBJ_W'(i)) begin
          case (wr_field)
            2'd0: w_nx_x[i] = wr_data;
            2'd1: w_nx_y[i] = wr_data;
            2'd2: begin
              w_nx_w[i] = wr_data[7:0];
              w_nx_h[i] = wr_data[15:8];
            end
            default: begin
              w_nx_c[i]  = wr_data[COLOR_W-1:0];
              w_nx_en[i] = wr_data[15];
            end
          endcase
        end
      end
    end
  end

  // One extra bit keeps x+w from wrapping, so right/bottom overhang is clipped.
  always_comb begin
    w_cov = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      w_cov[i] = r_ac_en[i]
              && (w_px >= {1'b0, r_ac_x[i]})
              && (w_px <  ({1'b0, r_ac_x[i]} + (COORD_W+1)'(r_ac_w[i])))
              && (w_py >= {1'b0, r_ac_y[i]})
              && (w_py <  ({1'b0, r_ac_y[i]} + (COORD_W+1)'(r_ac_h[i])));
    end
  end

  always_comb begin
    w_color = COLOR_W'(BG_COLOR);
    for (int unsigned k = 0; k < N_OBJ; k++) begin
      if (w_cov[N_OBJ-1-k]) w_color = r_ac_c[N_OBJ-1-k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_color     <= '0;
      r_addr      <= '0;
      r_fs        <= 1'b0;
      r_scan_x    <= '0;
      r_scan_y    <= '0;
      r_scan_addr <= '0;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        r_sh_x[i] <= '0;  r_sh_y[i] <= '0;  r_sh_w[i] <= '0;
        r_sh_h[i] <= '0;  r_sh_c[i] <= '0;  r_sh_en[i] <= 1'b0;
        r_ac_x[i] <= '0;  r_ac_y[i] <= '0;  r_ac_w[i] <= '0;
        r_ac_h[i] <= '0;  r_ac_c[i] <= '0;  r_ac_en[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        r_sh_x[i] <= w_nx_x[i];  r_sh_y[i] <= w_nx_y[i];  r_sh_w[i] <= w_nx_w[i];
        r_sh_h[i] <= w_nx_h[i];  r_sh_c[i] <= w_nx_c[i];  r_sh_en[i] <= w_nx_en[i];
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_color <= w_color;
        r_addr  <= r_scan_addr;
        r_fs    <= (r_scan_x == '0) && (r_scan_y == '0);
        if (w_last_x) begin
          r_scan_x <= '0;
          r_scan_y <= w_last_y ? '0 : r_scan_y + COORD_W'(1);
        end else begin
          r_scan_x <= r_scan_x + COORD_W'(1);
        end
        r_scan_addr <= w_last ? '0 : r_scan_addr + ADDR_W'(1);
        if (w_last) begin
          for (int unsigned i = 0; i < N_OBJ; i++) begin
            r_ac_x[i] <= w_nx_x[i];  r_ac_y[i] <= w_nx_y[i];  r_ac_w[i] <= w_nx_w[i];
            r_ac_h[i] <= w_nx_h[i];  r_ac_c[i] <= w_nx_c[i];  r_ac_en[i] <= w_nx_en[i];
          end
        end
      end
    end
  end

  assign pixel_valid   = r_valid;
  assign color         = r_color;
  assign pixel_address = r_addr;
  assign frame_start   = r_fs;

endmodule

// File: tb/tb_gfx_compositor.sv
// Directed bench for gfx_compositor on a reduced 32x24 raster with 5 objects and a
// non-zero background so reset color and background color are distinguishable.
module tb_gfx_compositor;
  localparam int H    = 32;
  localparam int V    = 24;
  localparam int NO   = 5;
  localparam int OW   = 3;
  localparam int CW   = 16;
  localparam int COLW = 3;
  localparam int AW   = 19;
  localparam int BG   = 1;
  localparam int NPIX = H * V;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [OW-1:0]   wr_obj = '0;
  logic [1:0]      wr_field = '0;
  logic [CW-1:0]   wr_data = '0;
  logic            pixel_ready = 1'b1;
  logic            pixel_valid;
  logic [COLW-1:0] color;
  logic [AW-1:0]   pixel_address;
  logic            frame_start;

  gfx_compositor #(
    .H_RES(H), .V_RES(V), .N_OBJ(NO), .COORD_W(CW), .COLOR_W(COLW), .ADDR_W(AW), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_obj(wr_obj), .wr_field(wr_field),
    .wr_data(wr_data), .pixel_ready(pixel_ready), .pixel_valid(pixel_valid),
    .color(color), .pixel_address(pixel_address), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int e_addr = 0;
  int sx[NO], sy[NO], sw[NO], sh[NO], sc[NO], sen[NO];
  int ax[NO], ay[NO], aw[NO], ah[NO], ac[NO], aen[NO];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_color(input int x, input int y);
    for (int i = 0; i < NO; i++)
      if (aen[i] != 0 && x >= ax[i] && x < ax[i] + aw[i] && y >= ay[i] && y < ay[i] + ah[i])
        return ac[i];
    return BG;
  endfunction

  task automatic set_shadow(input int obj, input int field, input int data);
    if (obj < NO) begin
      case (field)
        0: sx[obj] = data;
        1: sy[obj] = data;
        2: begin sw[obj] = data & 'hff; sh[obj] = (data >> 8) & 'hff; end
        default: begin sc[obj] = data & 7; sen[obj] = (data >> 15) & 1; end
      endcase
    end
  endtask

  task automatic swap_model();
    ax = sx; ay = sy; aw = sw; ah = sh; ac = sc; aen = sen;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NO; i++) begin
      sx[i] = 0; sy[i] = 0; sw[i] = 0; sh[i] = 0; sc[i] = 0; sen[i] = 0;
    end
    swap_model();
  endtask

  // Check the presented pixel, then optionally accept it on the next edge.
  task automatic step_px(input bit rdy);
    int x, y;
    x = e_addr % H;
    y = e_addr / H;
    chk($sformatf("valid@%0d", e_addr), 32'(pixel_valid), 32'd1);
    chk($sformatf("addr@%0d", e_addr), 32'(pixel_address), 32'(e_addr));
    chk($sformatf("fstart@%0d", e_addr), 32'(frame_start), 32'(e_addr == 0));
    chk($sformatf("color@%0d,%0d", x, y), 32'(color), 32'(exp_color(x, y)));
    pixel_ready = rdy;
    if (rdy) begin
      if (e_addr == NPIX - 1) swap_model();
      e_addr = (e_addr + 1) % NPIX;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step_px(1'b1);
  endtask

  // Register write issued while the stream is stalled; the presented pixel must hold.
  task automatic wr(input int obj, input int field, input int data);
    pixel_ready = 1'b0;
    wr_en = 1'b1;
    wr_obj = OW'(obj);
    wr_field = 2'(field);
    wr_data = CW'(data);
    @(negedge clk);
    set_shadow(obj, field, data);
    wr_en = 1'b0;
    chk("stall_addr", 32'(pixel_address), 32'(e_addr));
    chk("stall_valid", 32'(pixel_valid), 32'd1);
    pixel_ready = 1'b1;
  endtask

  initial begin
    int guard;
    clear_model();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    chk("rst_addr", 32'(pixel_address), 32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    e_addr = 0;

    run(NPIX);

    wr(0, 0, 10); wr(0, 1, 5); wr(0, 2, (6 << 8) | 8); wr(0, 3, 'h8005);
    run(NPIX);
    run(NPIX);

    wr(0, 0, 2); wr(0, 1, 2); wr(0, 2, (10 << 8) | 10); wr(0, 3, 'h8002);
    wr(1, 0, 8); wr(1, 1, 8); wr(1, 2, (10 << 8) | 10); wr(1, 3, 'h8006);
    wr(6, 0, 0); wr(6, 2, 'hffff); wr(6, 3, 'h8007);
    run(NPIX);
    run(NPIX);

    wr(0, 3, 'h0002);
    run(NPIX);
    run(NPIX);

    wr(2, 0, 28); wr(2, 1, 0); wr(2, 2, (3 << 8) | 10); wr(2, 3, 'h8003);
    wr(3, 0, 0); wr(3, 1, 0); wr(3, 2, (2 << 8) | 4); wr(3, 3, 'h0007);

    guard = 0;
    do begin
      step_px(1'($urandom_range(0, 1)));
      guard++;
    end while (e_addr != 0 && guard < 20000);
    chk("rand_frame_bound", 32'(guard < 20000), 32'd1);
    pixel_ready = 1'b1;

    run(NPIX - 2);
    wr_en = 1'b1; wr_obj = OW'(3); wr_field = 2'd3; wr_data = CW'('h8007);
    set_shadow(3, 3, 'h8007);
    step_px(1'b1);
    run(1);
    run(100);

    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(pixel_valid), 32'd0);
    chk("midrst_color", 32'(color), 32'd0);
    chk("midrst_addr", 32'(pixel_address), 32'd0);
    chk("midrst_fstart", 32'(frame_start), 32'd0);
    clear_model();
    rst = 1'b0;
    @(negedge clk);
    e_addr = 0;
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
